wbuff_bank_loader: RTL and testbench
====================================

// Module: wbuff_bank_loader
// PURPOSE
//  Control side of one weight-buffer bank (72x16 dual-port SRAM plus per-tap weight registers).
//  - Write side: drains a valid/ready weight stream into the SRAM.
//  - Read side: on command, reads nb_taps consecutive words and pulses the matching weight_load_en bit
//    exactly when each word appears on the SRAM Q port.
//  - Sits between the global weight DMA and the bank; one instance per PE column.
// PARAMETERS
//  nb_taps            11   weight registers per bank; words read per load command
//  buffer_depth       72   SRAM words; all addresses wrap modulo this value
//  buffer_width       16   SRAM word / stream data width
//  buffer_addr_width  clogb2(buffer_depth)   address width (7 at default)
// PORTS
//  clk              in   1         clock
//  rst_n            in   1         asynchronous active-low reset
//  fill_start       in   1         pulse: begin fill at fill_base for fill_len words
//  fill_base        in   AW        first write address
//  fill_len         in   AW+1      words to write; 0..buffer_depth (larger saturates to buffer_depth)
//  in_valid         in   1         stream word valid
//  in_ready         out  1         stream word accepted when in_valid&&in_ready
//  in_data          in   BW        stream word
//  fill_busy        out  1         fill in progress
//  fill_done        out  1         one-cycle pulse after last SRAM write is issued
//  load_start       in   1         pulse: begin tap load at load_base
//  load_base        in   AW        address of tap 0 weight
//  load_busy        out  1         load in progress
//  load_done        out  1         one-cycle pulse after last weight_load_en
//  wAddr, rAddr     out  AW        SRAM write / read address
//  buffer_data_in   out  BW        SRAM write data
//  buffer_wEn       out  1         SRAM write enable, ACTIVE-LOW (WEB)
//  buffer_rEn       out  1         SRAM read enable, ACTIVE-LOW (REB)
//  weight_load_en   out  nb_taps   one-hot per-tap register load strobe
//  clear_all_wregs  out  1         clears all bank weight registers (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0): both FSMs go to IDLE. All outputs are 0 except buffer_wEn=1 and buffer_rEn=1.
//    This applies mid-operation too: any in-flight write or read is abandoned and no done pulse is issued.
//  All SRAM-side outputs are registered. No combinational path exists from any input to wAddr,
//    rAddr, buffer_wEn, buffer_rEn, buffer_data_in or weight_load_en.
//  Write FSM, states IDLE -> FILL -> IDLE:
//    - fill_start in IDLE latches the write pointer (wptr=fill_base) and remaining count.
//      fill_start is ignored while fill_busy=1.
//    - In FILL, in_ready=1 unless a collision stall applies (see below).
//    - Each handshake at edge E drives buffer_wEn=0, wAddr=wptr, buffer_data_in=in_data for cycle E+1.
//      wptr then advances; address buffer_depth-1 wraps to 0.
//    - After the last handshake the FSM returns to IDLE and fill_done pulses in the same cycle as that write.
//    - fill_len=0: fill_done pulses the cycle after fill_start, with no writes.
//  Read FSM, states IDLE -> [CLR] -> READ -> DRAIN -> IDLE (k = 0..nb_taps-1):
//    - load_start in IDLE is taken at cycle 0. load_start is ignored while load_busy=1.
//    - READ: cycles 1..nb_taps drive buffer_rEn=0 and rAddr=(load_base+k) mod buffer_depth.
//    - SRAM read latency is 1 cycle, so weight_load_en = 1<<k is driven in cycle k+2.
//      Exactly one bit is high per cycle.
//    - DRAIN: covers the final strobe. load_done pulses in cycle nb_taps+2, then the FSM returns to IDLE.
//  Concurrency and collisions:
//    - Fill and load run concurrently.
//    - If the read address issued next cycle equals the pending write address, in_ready=0 for that
//      cycle (read wins). The write is retried the following cycle, with no word lost or duplicated.
//    - fill_start and load_start may arrive in the same cycle; the two are independent.
// CONFIGURATION
//  Macro WBUFF_LOADER_CLEAR_EN.
//  Defined:
//    - The read FSM enters CLR for one cycle after load_start and drives clear_all_wregs=1.
//    - All read, strobe and done timings shift by +1 cycle: load_done falls in cycle nb_taps+3.
//  Undefined:
//    - clear_all_wregs is tied to 0 and the CLR state does not exist.
// TESTING
//  1 Reset mid-fill at word 5 of 10 -> buffer_wEn=1, in_ready=0, fill_busy=0, no fill_done.
//    A new fill_start is then accepted.
//  2 fill_base=70, fill_len=4, data 0xA0..0xA3 -> writes addresses 70,71,0,1.
//    fill_done pulses with the write to address 1.
//  3 load_base=0 after a fill of 0x100+i at addr i -> weight_load_en=1<<k with Q=0x100+k in cycles 2..12.
//    load_done pulses in cycle 13 (one later with the macro, plus clear_all_wregs in cycle 1).
//  4 load_base=65 -> rAddr sequence 65..71,0..3, no gap at the wrap.
//  5 Load active on addresses 20..30 while a fill writes 18..25 -> in_ready drops on each collision cycle.
//    SRAM ends with all 8 words correct.
//  6 fill_start/load_start while busy, and fill_len=0 or 200 -> ignored; immediate fill_done; 72 writes.

Source files
------------

// File: rtl/wbuff_bank_loader.sv
// Control side of one weight-buffer bank: drains a weight stream into the SRAM and replays
// nb_taps words into the per-tap registers. WBUFF_LOADER_CLEAR_EN adds a clear cycle per load.
module wbuff_bank_loader #(
  parameter int unsigned nb_taps           = 11,
  parameter int unsigned buffer_depth      = 72,
  parameter int unsigned buffer_width      = 16,
  parameter int unsigned buffer_addr_width = $clog2(buffer_depth)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fill_start,
  input  logic [buffer_addr_width-1:0] fill_base,
  input  logic [buffer_addr_width:0]   fill_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [buffer_width-1:0]      in_data,
  output logic                         fill_busy,
  output logic                         fill_done,
  input  logic                         load_start,
  input  logic [buffer_addr_width-1:0] load_base,
  output logic                         load_busy,
  output logic                         load_done,
  output logic [buffer_addr_width-1:0] wAddr,
  output logic [buffer_addr_width-1:0] rAddr,
  output logic [buffer_width-1:0]      buffer_data_in,
  output logic                         buffer_wEn,
  output logic                         buffer_rEn,
  output logic [nb_taps-1:0]           weight_load_en,
  output logic                         clear_all_wregs
);

  localparam int unsigned AW = buffer_addr_width;
  localparam int unsigned TW = $clog2(nb_taps + 1);
  localparam logic [AW:0]   DepthLen = (AW + 1)'(buffer_depth);
  localparam logic [AW-1:0] LastAddr = AW'(buffer_depth - 1);
  localparam logic [TW-1:0] NbTaps   = TW'(nb_taps);

  typedef enum logic {WrIdle, WrFill} wr_state_e;
  typedef enum logic [1:0] {
    RdIdle,
`ifdef WBUFF_LOADER_CLEAR_EN
    RdClr,
`endif
    RdRead,
    RdDrain
  } rd_state_e;

  wr_state_e       wr_st_q;
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   wptr_nxt;
  logic [AW:0]     remain_q;
  logic [AW:0]     len_sat;

  rd_state_e       rd_st_q;
  logic [AW-1:0]   rptr_q;
  logic [TW-1:0]   tap_cnt_q;
  logic [nb_taps-1:0] rd_tap_q;

  logic            rd_nxt_vld;
  logic [AW-1:0]   rd_nxt_addr;
  logic [AW-1:0]   rd_nxt_ptr;
  logic [TW-1:0]   rd_nxt_cnt;

  assign len_sat   = (fill_len > DepthLen) ? DepthLen : fill_len;
  assign wptr_nxt  = (wptr_q == LastAddr) ? '0 : wptr_q + 1'b1;
  assign fill_busy = (wr_st_q == WrFill);
  assign load_busy = (rd_st_q != RdIdle);

  // Read issued next cycle; a matching pending write yields to it.
  always_comb begin
    rd_nxt_vld  = 1'b0;
    rd_nxt_addr = rptr_q;
    rd_nxt_cnt  = tap_cnt_q;
    case (rd_st_q)
      RdIdle: begin
        rd_nxt_addr = load_base;
        rd_nxt_cnt  = '0;
`ifndef WBUFF_LOADER_CLEAR_EN
        rd_nxt_vld  = load_start;
`endif
      end
`ifdef WBUFF_LOADER_CLEAR_EN
      RdClr:   rd_nxt_vld = 1'b1;
`endif
      RdRead:  rd_nxt_vld = (tap_cnt_q < NbTaps);
      default: rd_nxt_vld = 1'b0;
    endcase
    rd_nxt_ptr = (rd_nxt_addr == LastAddr) ? '0 : rd_nxt_addr + 1'b1;
  end

  assign in_ready = (wr_st_q == WrFill) && !(rd_nxt_vld && (rd_nxt_addr == wptr_q));

  // Write FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_st_q        <= WrIdle;
      wptr_q         <= '0;
      remain_q       <= '0;
      wAddr          <= '0;
      buffer_data_in <= '0;
      buffer_wEn     <= 1'b1;
      fill_done      <= 1'b0;
    end else begin
      buffer_wEn <= 1'b1;
      fill_done  <= 1'b0;
      case (wr_st_q)
        WrIdle: begin
          if (fill_start) begin
            wptr_q <= fill_base;
            if (len_sat == '0) begin
              fill_done <= 1'b1;
            end else begin
              remain_q <= len_sat;
              wr_st_q  <= WrFill;
            end
          end
        end
        WrFill: begin
          if (in_valid && in_ready) begin
            buffer_wEn     <= 1'b0;
            wAddr          <= wptr_q;
            buffer_data_in <= in_data;
            wptr_q         <= wptr_nxt;
            remain_q       <= remain_q - 1'b1;
            if (remain_q == (AW + 1)'(1)) begin
              wr_st_q   <= WrIdle;
              fill_done <= 1'b1;
            end
          end
        end
        default: wr_st_q <= WrIdle;
      endcase
    end
  end

  // Read FSM; weight_load_en trails the read by the one-cycle SRAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_st_q        <= RdIdle;
      rptr_q         <= '0;
      tap_cnt_q      <= '0;
      rd_tap_q       <= '0;
      rAddr          <= '0;
      buffer_rEn     <= 1'b1;
      weight_load_en <= '0;
      load_done      <= 1'b0;
    end else begin
      buffer_rEn     <= 1'b1;
      load_done      <= 1'b0;
      weight_load_en <= buffer_rEn ? '0 : rd_tap_q;
      if (rd_nxt_vld) begin
        rAddr      <= rd_nxt_addr;
        buffer_rEn <= 1'b0;
        rd_tap_q   <= nb_taps'(1) << rd_nxt_cnt;
        tap_cnt_q  <= rd_nxt_cnt + 1'b1;
        rptr_q     <= rd_nxt_ptr;
      end
      case (rd_st_q)
        RdIdle: begin
          if (load_start) begin
`ifdef WBUFF_LOADER_CLEAR_EN
            rd_st_q   <= RdClr;
            rptr_q    <= load_base;
            tap_cnt_q <= '0;
`else
            rd_st_q   <= RdRead;
`endif
          end
        end
`ifdef WBUFF_LOADER_CLEAR_EN
        RdClr:   rd_st_q <= RdRead;
`endif
        RdRead: begin
          if (!rd_nxt_vld) rd_st_q <= RdDrain;
        end
        RdDrain: begin
          load_done <= 1'b1;
          rd_st_q   <= RdIdle;
        end
        default: rd_st_q <= RdIdle;
      endcase
    end
  end

`ifdef WBUFF_LOADER_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_all_wregs <= 1'b0;
    end else begin
      clear_all_wregs <= (rd_st_q == RdIdle) && load_start;
    end
  end
`else
  assign clear_all_wregs = 1'b0;
`endif

endmodule

// File: tb/tb_wbuff_bank_loader.sv
// Scoreboard bench for wbuff_bank_loader: stimulus pushes expected SRAM writes, reads, strobes
// and done pulses; a negedge monitor pops and compares whenever the DUT presents one.
module tb_wbuff_bank_loader;
  localparam int NT = 11;
  localparam int D  = 72;
  localparam int AW = 7;
  localparam int BW = 16;
`ifdef WBUFF_LOADER_CLEAR_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fill_start = 1'b0;
  logic [AW-1:0] fill_base = '0;
  logic [AW:0]   fill_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          fill_busy, fill_done;
  logic          load_start = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic          load_busy, load_done;
  logic [AW-1:0] wAddr, rAddr;
  logic [BW-1:0] buffer_data_in;
  logic          buffer_wEn, buffer_rEn;
  logic [NT-1:0] weight_load_en;
  logic          clear_all_wregs;

  wbuff_bank_loader #(
    .nb_taps(NT), .buffer_depth(D), .buffer_width(BW), .buffer_addr_width(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fill_start(fill_start), .fill_base(fill_base),
    .fill_len(fill_len), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fill_busy(fill_busy), .fill_done(fill_done), .load_start(load_start),
    .load_base(load_base), .load_busy(load_busy), .load_done(load_done), .wAddr(wAddr),
    .rAddr(rAddr), .buffer_data_in(buffer_data_in), .buffer_wEn(buffer_wEn),
    .buffer_rEn(buffer_rEn), .weight_load_en(weight_load_en),
    .clear_all_wregs(clear_all_wregs)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int data; bit last;} wr_t;
  typedef struct {int addr; int cyc;} rd_t;
  typedef struct {int tap; int data; int cyc;} tap_t;

  wr_t  wq[$];
  rd_t  rq[$];
  tap_t tq[$];
  int   ldq[$], cq[$], fdq[$];

  logic [BW-1:0] exp_mem[D];
  logic [BW-1:0] sram[D];
  logic [BW-1:0] q_data;
  int cyc = 0;
  int total = 0, bad = 0, conflicts = 0, stalls = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model with one-cycle read latency
  always @(posedge clk) begin
    if (!buffer_rEn) q_data <= sram[rAddr];
    if (!buffer_wEn) sram[wAddr] <= buffer_data_in;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=event required=none (cycle %0d)", name, cyc);
  endtask

  wr_t  mw;
  rd_t  mr;
  tap_t mt;
  int   mc;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!buffer_wEn) begin
        if (wq.size() == 0) unexpected("write");
        else begin
          mw = wq.pop_front();
          check("wAddr", 32'(wAddr), mw.addr);
          check("wdata", 32'(buffer_data_in), mw.data);
          check("fill_done_at_write", 32'(fill_done), 32'(mw.last));
        end
      end else if (fill_done) begin
        if (fdq.size() == 0) unexpected("fill_done");
        else begin mc = fdq.pop_front(); check("fill_done_cycle", cyc, mc); end
      end
      if (!buffer_rEn) begin
        if (rq.size() == 0) unexpected("read");
        else begin
          mr = rq.pop_front();
          check("rAddr", 32'(rAddr), mr.addr);
          check("read_cycle", cyc, mr.cyc);
        end
      end
      if (weight_load_en != '0) begin
        if (tq.size() == 0) unexpected("weight_load_en");
        else begin
          mt = tq.pop_front();
          check("weight_load_en", 32'(weight_load_en), 32'(1) << mt.tap);
          check("tap_q", 32'(q_data), mt.data);
          check("strobe_cycle", cyc, mt.cyc);
        end
      end
      if (load_done) begin
        if (ldq.size() == 0) unexpected("load_done");
        else begin mc = ldq.pop_front(); check("load_done_cycle", cyc, mc); end
      end
      if (clear_all_wregs) begin
        if (cq.size() == 0) unexpected("clear_all_wregs");
        else begin mc = cq.pop_front(); check("clear_cycle", cyc, mc); end
      end
      if (!buffer_wEn && !buffer_rEn && wAddr == rAddr) conflicts++;
      if (fill_busy && !in_ready) stalls++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_fill(input int base, input int len, input int d0);
    for (int j = 0; j < len; j++) wq.push_back('{(base + j) % D, d0 + j, j == len - 1});
  endfunction

  function automatic void set_mem(input int base, input int len, input int d0);
    for (int j = 0; j < len; j++) exp_mem[(base + j) % D] = BW'(d0 + j);
  endfunction

  function automatic void push_load(input int l, input int base);
    int a;
    for (int k = 0; k < NT; k++) begin
      a = (base + k) % D;
      rq.push_back('{a, l + 1 + k + LAT});
      tq.push_back('{k, int'(exp_mem[a]), l + 2 + k + LAT});
    end
    ldq.push_back(l + NT + 2 + LAT);
    if (LAT != 0) cq.push_back(l + 1);
  endfunction

  task automatic do_fill(input int base, input int len);
    fill_start = 1'b1;
    fill_base  = AW'(base);
    fill_len   = (AW + 1)'(len);
    tick();
    fill_start = 1'b0;
  endtask

  task automatic do_load(input int base, input bit accept);
    load_start = 1'b1;
    load_base  = AW'(base);
    if (accept) push_load(cyc, base);
    tick();
    load_start = 1'b0;
  endtask

  task automatic stream(input int n, input int d0);
    bit hs;
    int guard;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = BW'(d0 + i);
      hs = 1'b0;
      guard = 0;
      while (!hs && guard < 50) begin
        @(negedge clk);
        hs = in_ready;
        tick();
        guard++;
      end
      if (!hs) unexpected("in_ready_timeout");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((wq.size() + rq.size() + tq.size() + ldq.size() + cq.size() + fdq.size() != 0 ||
            fill_busy || load_busy) && g < 400) begin
      tick();
      g++;
    end
    check("idle_within_budget", 32'(g < 400), 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    for (int i = 0; i < D; i++) exp_mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_wEn", 32'(buffer_wEn), 1);
    check("rst_rEn", 32'(buffer_rEn), 1);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_wle", 32'(weight_load_en), 0);
    check("rst_busy", 32'({fill_busy, load_busy, fill_done, load_done, clear_all_wregs}), 0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a 10-word fill, right after word 5 is written
    push_fill(0, 10, 'h300);
    do_fill(0, 10);
    stream(5, 'h300);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_wEn", 32'(buffer_wEn), 1);
    check("midrst_in_ready", 32'(in_ready), 0);
    check("midrst_fill_busy", 32'(fill_busy), 0);
    check("midrst_fill_done", 32'(fill_done), 0);
    wq.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    repeat (3) tick();

    // fill_len=200 saturates to 72 words; a fill_start while busy is ignored
    push_fill(0, D, 'h100);
    set_mem(0, D, 'h100);
    do_fill(0, 200);
    check("fill_busy_after_start", 32'(fill_busy), 1);
    fork
      stream(D, 'h100);
      begin
        repeat (10) tick();
        do_fill(50, 3);
      end
    join
    wait_idle();

    // Load from 0, plus an ignored load_start while busy
    do_load(0, 1'b1);
    check("load_busy", 32'(load_busy), 1);
    repeat (3) tick();
    do_load(40, 1'b0);
    wait_idle();

    // Load wrapping across the end of the buffer
    do_load(65, 1'b1);
    wait_idle();

    // fill_len=0 together with load_start in the same cycle
    fill_start = 1'b1;
    fill_base  = AW'(5);
    fill_len   = '0;
    fdq.push_back(cyc + 1);
    do_load(10, 1'b1);
    fill_start = 1'b0;
    wait_idle();

    // Fill wrapping across the end: 70,71,0,1, then read them back
    push_fill(70, 4, 'hA0);
    set_mem(70, 4, 'hA0);
    do_fill(70, 4);
    stream(4, 'hA0);
    wait_idle();
    do_load(68, 1'b1);
    wait_idle();

    // Fill 18..25 concurrently with a load of 20..30; one collision stall on address 20
    stalls = 0;
    push_fill(18, 8, 'hC0);
    do_fill(18, 8);
    fork
      stream(8, 'hC0);
      begin
        tick();
        tick();
        do_load(20, 1'b1);
      end
    join
    set_mem(18, 8, 'hC0);
    wait_idle();
    check("collision_stalls", stalls, 1);
    check("rw_same_addr", conflicts, 0);

    for (int i = 0; i < D; i++) check($sformatf("sram[%0d]", i), 32'(sram[i]), 32'(exp_mem[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
